// File: rtl/video_timing_pkg.sv
// Purpose: shared raster-timing constants (720p60 defaults), counter widths,
//          the decoded sync bundle and a wrapping-increment helper.
// Ports:   none (package).
package video_timing_pkg;

  // Counter widths, also used by the sprite/pixel stages
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FC_W     = 6;

  // 1280x720@60 timing, 74.25 MHz pixel clock
  localparam int unsigned DEF_ACTIVE_H_PIXELS = 1280;
  localparam int unsigned DEF_H_FRONT_PORCH   = 110;
  localparam int unsigned DEF_H_SYNC_WIDTH    = 40;
  localparam int unsigned DEF_H_BACK_PORCH    = 220;
  localparam int unsigned DEF_ACTIVE_LINES    = 720;
  localparam int unsigned DEF_V_FRONT_PORCH   = 5;
  localparam int unsigned DEF_V_SYNC_WIDTH    = 5;
  localparam int unsigned DEF_V_BACK_PORCH    = 20;
  localparam int unsigned DEF_FPS             = 60;

  localparam int unsigned DEF_H_TOTAL = DEF_ACTIVE_H_PIXELS + DEF_H_FRONT_PORCH
                                      + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
  localparam int unsigned DEF_V_TOTAL = DEF_ACTIVE_LINES + DEF_V_FRONT_PORCH
                                      + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

  // Per-pixel decoded timing flags
  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
    logic nf;
  } sync_t;

  // Next value of a counter that runs 0..max_val and then wraps
  function automatic int unsigned wrap_inc(input int unsigned cur,
                                           input int unsigned max_val);
    return (cur >= max_val) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/evt_counter.sv
// Purpose: wrapping event counter, 0..MAX, advancing by one on each evt.
// Ports:   clk   - clock
//          rst   - synchronous reset, active high, loads RST_VAL
//          evt   - advance enable
//          count - registered count value
module evt_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned MAX     = 255,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         evt,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= W'(RST_VAL);
    end else if (evt) begin
      r_count <= W'(wrap_inc(32'(r_count), MAX));
    end
  end

  assign count = r_count;

endmodule

// File: rtl/video_sig_gen.sv
// Purpose: raster timing generator. Produces pixel position, hsync, vsync,
//          active-draw, a one-cycle new-frame strobe and a frame counter.
//          Every output is registered and all describe the same pixel.
// Ports:   pixel_clk_in - pixel clock
//          rst_in       - synchronous reset, active high
//          hcount_out   - horizontal position, 0..H_TOTAL-1
//          vcount_out   - vertical position, 0..V_TOTAL-1
//          hs_out       - hsync, active high
//          vs_out       - vsync, active high
//          ad_out       - active draw
//          nf_out       - new-frame strobe at (ACTIVE_H_PIXELS, ACTIVE_LINES)
//          fc_out       - frame count, 0..FPS-1
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
  parameter int unsigned H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int unsigned H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int unsigned ACTIVE_LINES    = DEF_ACTIVE_LINES,
  parameter int unsigned V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter int unsigned V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter int unsigned FPS             = DEF_FPS
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int unsigned H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH
                                  + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH
                                  + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(ACTIVE_H_PIXELS);
  localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH
                                                       + H_SYNC_WIDTH);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(ACTIVE_LINES);
  localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH
                                                       + V_SYNC_WIDTH);

  logic [HCOUNT_W-1:0] w_hcount;
  logic [HCOUNT_W-1:0] w_hcount_nxt;
  logic [VCOUNT_W-1:0] w_vcount;
  logic [VCOUNT_W-1:0] w_vcount_nxt;
  logic [FC_W-1:0]     w_fc;
  logic                w_h_wrap;
  sync_t               w_sync_nxt;
  sync_t               r_sync;

  // Horizontal position; reset parks on the last blanking pixel so the
  // first released edge lands on (0,0)
  evt_counter #(
    .W       (HCOUNT_W),
    .MAX     (H_TOTAL - 1),
    .RST_VAL (H_TOTAL - 1)
  ) u_hcount (
    .clk   (pixel_clk_in),
    .rst   (rst_in),
    .evt   (1'b1),
    .count (w_hcount)
  );

  assign w_h_wrap = (w_hcount == H_LAST);

  // Vertical position, advances when the line wraps
  evt_counter #(
    .W       (VCOUNT_W),
    .MAX     (V_TOTAL - 1),
    .RST_VAL (V_TOTAL - 1)
  ) u_vcount (
    .clk   (pixel_clk_in),
    .rst   (rst_in),
    .evt   (w_h_wrap),
    .count (w_vcount)
  );

  // Frame counter, advances on the same edge that raises nf_out
  evt_counter #(
    .W       (FC_W),
    .MAX     (FPS - 1),
    .RST_VAL (0)
  ) u_fc (
    .clk   (pixel_clk_in),
    .rst   (rst_in),
    .evt   (w_sync_nxt.nf),
    .count (w_fc)
  );

  // Position the counters will hold after this edge
  always_comb begin
    w_hcount_nxt = HCOUNT_W'(wrap_inc(32'(w_hcount), H_TOTAL - 1));
    w_vcount_nxt = w_vcount;
    if (w_h_wrap) begin
      w_vcount_nxt = VCOUNT_W'(wrap_inc(32'(w_vcount), V_TOTAL - 1));
    end
  end

  // Decode flags from the next position so they register alongside it
  always_comb begin
    w_sync_nxt    = '0;
    w_sync_nxt.hs = (w_hcount_nxt >= HS_START) && (w_hcount_nxt < HS_END);
    w_sync_nxt.vs = (w_vcount_nxt >= VS_START) && (w_vcount_nxt < VS_END);
    w_sync_nxt.ad = (w_hcount_nxt < H_ACT) && (w_vcount_nxt < V_ACT);
    w_sync_nxt.nf = (w_hcount_nxt == H_ACT) && (w_vcount_nxt == V_ACT);
  end

  // Flag register; reset drops any sync pulse in progress
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_sync_nxt;
    end
  end

  assign hcount_out = w_hcount;
  assign vcount_out = w_vcount;
  assign hs_out     = r_sync.hs;
  assign vs_out     = r_sync.vs;
  assign ad_out     = r_sync.ad;
  assign nf_out     = r_sync.nf;
  assign fc_out     = w_fc;

endmodule
